keypad_entry_sequencer: RTL

//  Sequences keypad entry into an 8-digit BCD buffer with per-digit decimal points. The buffer feeds the
//  7-segment display path (number/dp_list) and is handed to the system controller by a valid/ready commit.

---
 rtl/keypad_entry_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/keypad_entry_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_entry_sequencer
//  Description : Collects debounced keypad codes into an 8-digit BCD buffer
//                with per-digit decimal points. Supports backspace, clear
//                and an idle timeout. Hands the buffer to the system
//                controller through a valid/ready commit.
//  Revision    : 1.0 - initial release
// ============================================================================
module keypad_entry_sequencer #(
  parameter int MAX_DIGITS     = 8,
  parameter int TIMEOUT_CYCLES = 10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic        commit_ready,
  output logic [31:0] number,
  output logic [7:0]  dp_list,
  output logic [7:0]  digit_en,
  output logic        commit_valid,
  output logic [31:0] commit_number,
  output logic [7:0]  commit_dp,
  output logic [1:0]  entry_state,
  output logic        err_pulse
);

  // State encoding, also presented directly on entry_state
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ENTRY  = 2'd1;
  localparam logic [1:0] S_COMMIT = 2'd2;

  // Key codes
  localparam logic [3:0] K_DP    = 4'hA;
  localparam logic [3:0] K_BACK  = 4'hB;
  localparam logic [3:0] K_CLEAR = 4'hC;
  localparam logic [3:0] K_ENTER = 4'hD;

  // Buffer capacity in digits
  localparam logic [3:0] C_FULL = 4'(MAX_DIGITS);

  // Idle counter width; it only needs to reach TIMEOUT_CYCLES-1
  localparam int          TW     = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] C_TMAX = TW'(TIMEOUT_CYCLES - 1);

  logic [1:0]    r_state;
  logic [1:0]    w_state_nxt;
  logic [3:0]    r_count;
  logic [3:0]    w_count_nxt;
  logic [TW-1:0] r_timer;
  logic [TW-1:0] w_timer_nxt;

  logic [31:0]   w_number_nxt;
  logic [7:0]    w_dp_nxt;
  logic [7:0]    w_en_nxt;
  logic          w_cv_nxt;
  logic [31:0]   w_cnum_nxt;
  logic [7:0]    w_cdp_nxt;
  logic          w_err_nxt;

  // Key decode. Keys are only honoured outside COMMIT.
  logic w_key;
  logic w_is_digit;
  logic w_empty;
  logic w_dig_ok, w_dig_err;
  logic w_dp_ok, w_dp_err;
  logic w_bs_dp, w_bs_shift, w_bs_err;
  logic w_clr;
  logic w_ent_ok, w_ent_err;
  logic w_expire;
  logic w_xfer;

  assign w_key      = key_valid && (r_state != S_COMMIT);
  assign w_is_digit = (key_code <= 4'd9);
  assign w_empty    = (r_count == 4'd0);

  assign w_dig_ok   = w_key && w_is_digit && (r_count <  C_FULL);
  assign w_dig_err  = w_key && w_is_digit && (r_count >= C_FULL);

  // Only one decimal point may exist in the buffer at a time
  assign w_dp_ok    = w_key && (key_code == K_DP) && !w_empty && (dp_list == 8'h00);
  assign w_dp_err   = w_key && (key_code == K_DP) && !w_dp_ok;

  // Backspace removes a trailing decimal point before removing a digit
  assign w_bs_dp    = w_key && (key_code == K_BACK) && dp_list[0];
  assign w_bs_shift = w_key && (key_code == K_BACK) && !dp_list[0] && !w_empty;
  assign w_bs_err   = w_key && (key_code == K_BACK) && !dp_list[0] && w_empty;

  assign w_clr      = w_key && (key_code == K_CLEAR);
  assign w_ent_ok   = w_key && (key_code == K_ENTER) && !w_empty;
  assign w_ent_err  = w_key && (key_code == K_ENTER) && w_empty;

  // A keypress in the expiry cycle takes priority over the timeout
  assign w_expire   = (r_state == S_ENTRY) && !key_valid && (r_timer == C_TMAX);
  assign w_xfer     = (r_state == S_COMMIT) && commit_valid && commit_ready;

  assign entry_state = r_state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_ENTRY: begin
        if (w_dig_ok) begin
          w_state_nxt = S_ENTRY;
        end else if (w_bs_shift && (r_count == 4'd1)) begin
          w_state_nxt = S_IDLE;
        end else if (w_clr || w_expire) begin
          w_state_nxt = S_IDLE;
        end else if (w_ent_ok) begin
          w_state_nxt = S_COMMIT;
        end
      end
      S_COMMIT: begin
        if (w_xfer) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Next values for the buffer, commit registers, error pulse and idle timer
  always_comb begin
    w_number_nxt = number;
    w_dp_nxt     = dp_list;
    w_en_nxt     = digit_en;
    w_count_nxt  = r_count;
    w_cv_nxt     = commit_valid;
    w_cnum_nxt   = commit_number;
    w_cdp_nxt    = commit_dp;
    w_err_nxt    = w_dig_err || w_dp_err || w_bs_err || w_ent_err;

    if (w_xfer || w_clr || w_expire) begin
      w_number_nxt = 32'h0;
      w_dp_nxt     = 8'h00;
      w_en_nxt     = 8'h00;
      w_count_nxt  = 4'd0;
      if (w_xfer) begin
        w_cv_nxt = 1'b0;
      end
    end else if (w_dig_ok) begin
      w_number_nxt = {number[27:0], key_code};
      w_dp_nxt     = {dp_list[6:0], 1'b0};
      w_en_nxt     = {digit_en[6:0], 1'b1};
      w_count_nxt  = r_count + 4'd1;
    end else if (w_dp_ok) begin
      w_dp_nxt     = dp_list | 8'h01;
    end else if (w_bs_dp) begin
      w_dp_nxt     = dp_list & 8'hFE;
    end else if (w_bs_shift) begin
      w_number_nxt = {4'h0, number[31:4]};
      w_dp_nxt     = {1'b0, dp_list[7:1]};
      w_en_nxt     = {1'b0, digit_en[7:1]};
      w_count_nxt  = r_count - 4'd1;
    end else if (w_ent_ok) begin
      w_cnum_nxt   = number;
      w_cdp_nxt    = dp_list;
      w_cv_nxt     = 1'b1;
    end

    // The idle timer only advances while editing and restarts on any key
    if ((r_state != S_ENTRY) || key_valid || w_expire) begin
      w_timer_nxt = '0;
    end else begin
      w_timer_nxt = r_timer + TW'(1);
    end
  end

  // Registered outputs and datapath state
  always_ff @(posedge clk) begin
    if (rst) begin
      number        <= 32'h0;
      dp_list       <= 8'h00;
      digit_en      <= 8'h00;
      r_count       <= 4'd0;
      r_timer       <= '0;
      commit_valid  <= 1'b0;
      commit_number <= 32'h0;
      commit_dp     <= 8'h00;
      err_pulse     <= 1'b0;
    end else begin
      number        <= w_number_nxt;
      dp_list       <= w_dp_nxt;
      digit_en      <= w_en_nxt;
      r_count       <= w_count_nxt;
      r_timer       <= w_timer_nxt;
      commit_valid  <= w_cv_nxt;
      commit_number <= w_cnum_nxt;
      commit_dp     <= w_cdp_nxt;
      err_pulse     <= w_err_nxt;
    end
  end

endmodule
`default_nettype wire
